// File: rtl/bip_dbg_pkg.sv
// Shared constants for the BIP UART debug unit: command bytes, FSM states,
// status bit positions and the word-to-byte sizing helper.
package bip_dbg_pkg;

  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_DUMP = 8'h44;
  localparam logic [7:0] CMD_HALT = 8'h48;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_STEP  = 3'd1,
    ST_RUN   = 3'd2,
    ST_LATCH = 3'd3,
    ST_SEND  = 3'd4,
    ST_WAIT  = 3'd5
  } state_t;

  localparam int STAT_HALT    = 0;
  localparam int STAT_TIMEOUT = 1;
  localparam int NB_STATUS    = 2;

  // Number of UART bytes needed to carry one debug word.
  function automatic int f_nbytes(input int nb_word, input int nb_byte);
    return (nb_word + nb_byte - 1) / nb_byte;
  endfunction

endpackage

// File: rtl/bip_dbg_frame_mux.sv
// Combinational frame byte selector: byte 0 is the status byte, then each
// snapshot word most-significant byte first, zero-padded to whole bytes.
module bip_dbg_frame_mux
  import bip_dbg_pkg::*;
#(
  parameter int NB_WORD = 16,
  parameter int N_WORDS = 3,
  parameter int NB_BYTE = 8,
  parameter int NB_SEL  = 3
) (
  input  logic [NB_STATUS-1:0]       status,
  input  logic [N_WORDS*NB_WORD-1:0] snapshot,
  input  logic [NB_SEL-1:0]          sel,
  output logic [NB_BYTE-1:0]         frame_byte
);

  localparam int NB_BYTES  = f_nbytes(NB_WORD, NB_BYTE);
  localparam int FRAME_LEN = 1 + N_WORDS * NB_BYTES;

  logic [FRAME_LEN*NB_BYTE-1:0] frame;

  assign frame[NB_BYTE-1:0] = NB_BYTE'(status);

  for (genvar w = 0; w < N_WORDS; w++) begin : g_word
    logic [NB_BYTES*NB_BYTE-1:0] padded;

    always_comb begin
      padded = '0;
      padded[NB_WORD-1:0] = snapshot[w*NB_WORD +: NB_WORD];
    end

    // Byte b of a word counts from its most-significant end.
    for (genvar b = 0; b < NB_BYTES; b++) begin : g_byte
      assign frame[(1 + w*NB_BYTES + b)*NB_BYTE +: NB_BYTE] =
        padded[(NB_BYTES-1-b)*NB_BYTE +: NB_BYTE];
    end
  end

  always_comb begin
    frame_byte = '0;
    for (int j = 0; j < FRAME_LEN; j++) begin
      if (sel == NB_SEL'(j)) frame_byte = frame[j*NB_BYTE +: NB_BYTE];
    end
  end

endmodule

// File: rtl/bip_uart_debug_unit.sv
// Debug bridge between the UART and the BIP: gates execution in run/step
// mode and streams a status byte plus a register snapshot back over the UART.
module bip_uart_debug_unit
  import bip_dbg_pkg::*;
#(
  parameter int NB_WORD     = 16,
  parameter int N_WORDS     = 3,
  parameter int NB_BYTE     = 8,
  parameter int NB_TIMEOUT  = 24,
  parameter int RUN_TIMEOUT = 2**24-1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NB_BYTE-1:0]         i_rx_data,
  input  logic                       i_rx_done,
  input  logic                       i_tx_done,
  input  logic [N_WORDS*NB_WORD-1:0] i_snapshot,
  input  logic                       i_halt,
  output logic [NB_BYTE-1:0]         o_data,
  output logic                       o_tx_start,
  output logic                       o_valid,
  output logic                       o_busy,
  output logic                       o_cmd_err
);

  localparam int NB_BYTES  = f_nbytes(NB_WORD, NB_BYTE);
  localparam int FRAME_LEN = 1 + N_WORDS * NB_BYTES;
  localparam int NB_SEL    = $clog2(FRAME_LEN);
  localparam logic [NB_SEL-1:0]     LAST_BYTE    = NB_SEL'(FRAME_LEN - 1);
  localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST = NB_TIMEOUT'(RUN_TIMEOUT - 1);

  state_t                     state, state_next;
  logic [NB_SEL-1:0]          byte_cnt, byte_cnt_next;
  logic [NB_TIMEOUT-1:0]      run_cnt, run_cnt_next;
  logic [N_WORDS*NB_WORD-1:0] snap_reg, snap_next;
  logic [NB_STATUS-1:0]       status, status_next;
  logic [NB_BYTE-1:0]         data_next, frame_byte;
  logic                       tx_start_next, valid_next, busy_next, cmd_err_next;
  logic                       is_break, timeout_hit;

  bip_dbg_frame_mux #(
    .NB_WORD(NB_WORD),
    .N_WORDS(N_WORDS),
    .NB_BYTE(NB_BYTE),
    .NB_SEL (NB_SEL)
  ) u_frame_mux (
    .status    (status),
    .snapshot  (snap_reg),
    .sel       (byte_cnt),
    .frame_byte(frame_byte)
  );

  assign is_break    = i_rx_done && (i_rx_data == NB_BYTE'(CMD_HALT));
  assign timeout_hit = (run_cnt == TIMEOUT_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      run_cnt    <= '0;
      snap_reg   <= '0;
      status     <= '0;
      o_data     <= '0;
      o_tx_start <= 1'b0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
      o_cmd_err  <= 1'b0;
    end else begin
      state      <= state_next;
      byte_cnt   <= byte_cnt_next;
      run_cnt    <= run_cnt_next;
      snap_reg   <= snap_next;
      status     <= status_next;
      o_data     <= data_next;
      o_tx_start <= tx_start_next;
      o_valid    <= valid_next;
      o_busy     <= busy_next;
      o_cmd_err  <= cmd_err_next;
    end
  end

  always_comb begin
    state_next    = state;
    byte_cnt_next = byte_cnt;
    run_cnt_next  = run_cnt;
    snap_next     = snap_reg;
    status_next   = status;
    data_next     = o_data;
    tx_start_next = 1'b0;
    cmd_err_next  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (i_rx_done) begin
          if (i_rx_data == NB_BYTE'(CMD_RUN)) begin
            state_next   = ST_RUN;
            run_cnt_next = '0;
          end else if (i_rx_data == NB_BYTE'(CMD_STEP)) begin
            state_next = ST_STEP;
          end else if (i_rx_data == NB_BYTE'(CMD_DUMP)) begin
            state_next = ST_LATCH;
          end else begin
            cmd_err_next = 1'b1;
          end
        end
      end
      ST_STEP: begin
        cmd_err_next = i_rx_done;
        state_next   = ST_LATCH;
      end
      ST_RUN: begin
        run_cnt_next = run_cnt + NB_TIMEOUT'(1);
        // A user break wins over halt/timeout and reports a clean status.
        if (is_break) begin
          status_next = '0;
          state_next  = ST_LATCH;
        end else begin
          cmd_err_next = i_rx_done;
          if (i_halt || timeout_hit) begin
            status_next[STAT_HALT]    = i_halt;
            status_next[STAT_TIMEOUT] = timeout_hit;
            state_next                = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        cmd_err_next  = i_rx_done;
        snap_next     = i_snapshot;
        byte_cnt_next = '0;
        state_next    = ST_SEND;
      end
      ST_SEND: begin
        cmd_err_next  = i_rx_done;
        data_next     = frame_byte;
        tx_start_next = 1'b1;
        state_next    = ST_WAIT;
      end
      ST_WAIT: begin
        cmd_err_next = i_rx_done;
        if (i_tx_done) begin
          if (byte_cnt == LAST_BYTE) begin
            status_next  = '0;
            run_cnt_next = '0;
            state_next   = ST_IDLE;
          end else begin
            byte_cnt_next = byte_cnt + NB_SEL'(1);
            state_next    = ST_SEND;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    valid_next = (state_next == ST_STEP) || (state_next == ST_RUN);
    busy_next  = (state_next != ST_IDLE);
  end

endmodule

// File: tb/tb_bip_uart_debug_unit.sv
// Scoreboard bench for bip_uart_debug_unit: a 16x3 instance with a short run
// timeout covers the command set, and an 11x4 instance covers byte padding.
module tb_bip_uart_debug_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done, tx_done, halt;
  logic [47:0] snapshot;
  logic [7:0]  data;
  logic        tx_start, valid, busy, cmd_err;

  logic [7:0]  b_rx_data;
  logic        b_rx_done, b_tx_done, b_halt;
  logic [43:0] b_snapshot;
  logic [7:0]  b_data;
  logic        b_tx_start, b_valid, b_busy, b_cmd_err;

  int vectors = 0;
  int miscompares = 0;
  int tx_seen = 0;
  int b_tx_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] b_exp_q[$];

  always #5 clk = ~clk;

  bip_uart_debug_unit #(
    .NB_WORD(16), .N_WORDS(3), .NB_BYTE(8), .NB_TIMEOUT(24), .RUN_TIMEOUT(100)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_done(tx_done), .i_snapshot(snapshot), .i_halt(halt),
    .o_data(data), .o_tx_start(tx_start), .o_valid(valid), .o_busy(busy),
    .o_cmd_err(cmd_err)
  );

  bip_uart_debug_unit #(
    .NB_WORD(11), .N_WORDS(4), .NB_BYTE(8), .NB_TIMEOUT(24), .RUN_TIMEOUT(100)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_rx_data(b_rx_data), .i_rx_done(b_rx_done),
    .i_tx_done(b_tx_done), .i_snapshot(b_snapshot), .i_halt(b_halt),
    .o_data(b_data), .o_tx_start(b_tx_start), .o_valid(b_valid), .o_busy(b_busy),
    .o_cmd_err(b_cmd_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame for the 16-bit instance: status, then words MSB first.
  task automatic pushFrameA(input logic [7:0] st, input logic [47:0] snap);
    exp_q.push_back(st);
    for (int w = 0; w < 3; w++) begin
      exp_q.push_back(snap[w*16+8 +: 8]);
      exp_q.push_back(snap[w*16 +: 8]);
    end
  endtask

  // UART transmitter model plus scoreboard for the main instance.
  initial begin : uart_a
    int   pending;
    logic outstanding;
    pending = 0;
    outstanding = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (rst) begin
        pending = 0;
        outstanding = 1'b0;
      end else begin
        if (pending > 0) begin
          pending--;
          if (pending == 0) begin
            tx_done = 1'b1;
            outstanding = 1'b0;
          end
        end
        if (tx_start) begin
          checkOutput("tx_after_done", 32'(outstanding), 32'd0);
          checkOutput("frame_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) checkOutput("frame_byte", 32'(data), 32'(exp_q.pop_front()));
          outstanding = 1'b1;
          pending = 3;
          tx_seen++;
        end
      end
    end
  end

  initial begin : uart_b
    int pending;
    pending = 0;
    b_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      b_tx_done = 1'b0;
      if (pending > 0) begin
        pending--;
        if (pending == 0) b_tx_done = 1'b1;
      end
      if (b_tx_start) begin
        checkOutput("b_frame_expected", 32'(b_exp_q.size() != 0), 32'd1);
        if (b_exp_q.size() != 0) checkOutput("b_frame_byte", 32'(b_data), 32'(b_exp_q.pop_front()));
        pending = 2;
        b_tx_seen++;
      end
    end
  end

  // Issue one command to the main instance and follow it until it is idle again.
  task automatic applyStimulus(input logic [7:0] cmd, input int halt_at, input int inj_cyc,
                               input logic [7:0] inj_byte, output int vcnt, output int ecnt,
                               output int first_tx);
    int cyc;
    bit done;
    vcnt = 0; ecnt = 0; first_tx = -1; cyc = 0; done = 1'b0;
    rx_data = cmd;
    rx_done = 1'b1;
    while (!done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      rx_done = 1'b0;
      if (valid) vcnt++;
      if (cmd_err) ecnt++;
      if (tx_start && first_tx < 0) first_tx = cyc;
      if (halt_at > 0 && vcnt == halt_at) halt = 1'b1;
      if (cyc == inj_cyc) begin
        rx_data = inj_byte;
        rx_done = 1'b1;
      end
      if (cyc >= 3 && !busy && !rx_done) done = 1'b1;
    end
    halt = 1'b0;
    checkOutput("cmd_completes", 32'(done), 32'd1);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_data"},     32'(data),     32'd0);
    checkOutput({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    checkOutput({tag, "_valid"},    32'(valid),    32'd0);
    checkOutput({tag, "_busy"},     32'(busy),     32'd0);
    checkOutput({tag, "_cmd_err"},  32'(cmd_err),  32'd0);
  endtask

  initial begin : main
    int vcnt, ecnt, first_tx, t0, guard;
    rst = 1'b1;
    rx_data = 8'h00; rx_done = 1'b0; halt = 1'b0; snapshot = '0;
    b_rx_data = 8'h00; b_rx_done = 1'b0; b_halt = 1'b0; b_snapshot = '0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    rst = 1'b0;
    @(negedge clk);

    t0 = tx_seen;
    applyStimulus(8'h41, 0, 0, 8'h00, vcnt, ecnt, first_tx);
    checkOutput("bad_cmd_err", 32'(ecnt), 32'd1);
    checkOutput("bad_cmd_valid", 32'(vcnt), 32'd0);
    checkOutput("bad_cmd_tx", 32'(tx_seen - t0), 32'd0);

    snapshot = {16'h0005, 16'h1803, 16'h00A7};
    pushFrameA(8'h00, snapshot);
    applyStimulus(8'h53, 0, 0, 8'h00, vcnt, ecnt, first_tx);
    checkOutput("step_valid", 32'(vcnt), 32'd1);
    checkOutput("step_latency", 32'(first_tx), 32'd4);
    checkOutput("step_frame_done", 32'(exp_q.size()), 32'd0);

    snapshot = {16'h0014, 16'h7000, 16'h1234};
    pushFrameA(8'h01, snapshot);
    applyStimulus(8'h52, 20, 0, 8'h00, vcnt, ecnt, first_tx);
    checkOutput("halt_valid_20_21", 32'(vcnt >= 20 && vcnt <= 21), 32'd1);
    checkOutput("halt_frame_done", 32'(exp_q.size()), 32'd0);

    // Abort a dump after its third byte, then dump again from the start.
    snapshot = {16'hBEEF, 16'hCAFE, 16'h0102};
    pushFrameA(8'h00, snapshot);
    t0 = tx_seen;
    rx_data = 8'h44; rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    guard = 0;
    while (tx_seen - t0 < 3 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("abort_reached_byte2", 32'(tx_seen - t0), 32'd3);
    #2 rst = 1'b1;
    #1 checkIdleOutputs("abort");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_idle", 32'(busy), 32'd0);
    pushFrameA(8'h00, snapshot);
    t0 = tx_seen;
    applyStimulus(8'h44, 0, 0, 8'h00, vcnt, ecnt, first_tx);
    checkOutput("dump_latency", 32'(first_tx), 32'd3);
    checkOutput("dump_len", 32'(tx_seen - t0), 32'd7);
    checkOutput("dump_frame_done", 32'(exp_q.size()), 32'd0);

    snapshot = {16'h0064, 16'h8001, 16'hFFFF};
    pushFrameA(8'h02, snapshot);
    applyStimulus(8'h52, 0, 0, 8'h00, vcnt, ecnt, first_tx);
    checkOutput("timeout_valid", 32'(vcnt), 32'd100);
    checkOutput("timeout_frame_done", 32'(exp_q.size()), 32'd0);

    snapshot = {16'h0065, 16'h7000, 16'h0042};
    pushFrameA(8'h03, snapshot);
    applyStimulus(8'h52, 100, 0, 8'h00, vcnt, ecnt, first_tx);
    checkOutput("both_valid", 32'(vcnt), 32'd100);
    checkOutput("both_frame_done", 32'(exp_q.size()), 32'd0);

    snapshot = {16'h000A, 16'h0C01, 16'h5555};
    pushFrameA(8'h00, snapshot);
    applyStimulus(8'h52, 0, 10, 8'h48, vcnt, ecnt, first_tx);
    checkOutput("break_valid", 32'(vcnt), 32'd10);
    checkOutput("break_err", 32'(ecnt), 32'd0);
    checkOutput("break_frame_done", 32'(exp_q.size()), 32'd0);

    snapshot = {16'h1111, 16'h2222, 16'h3333};
    pushFrameA(8'h00, snapshot);
    applyStimulus(8'h44, 0, 6, 8'h53, vcnt, ecnt, first_tx);
    checkOutput("busy_cmd_err", 32'(ecnt), 32'd1);
    checkOutput("busy_cmd_valid", 32'(vcnt), 32'd0);
    checkOutput("busy_cmd_frame_done", 32'(exp_q.size()), 32'd0);

    // 11-bit words: top byte carries only the upper 3 bits.
    b_snapshot = {11'h5A5, 11'h000, 11'h123, 11'h7FF};
    foreach (b_exp_q[i]) b_exp_q.delete(i);
    b_exp_q = '{8'h00, 8'h07, 8'hFF, 8'h01, 8'h23, 8'h00, 8'h00, 8'h05, 8'hA5};
    t0 = b_tx_seen;
    b_rx_data = 8'h44; b_rx_done = 1'b1;
    @(negedge clk);
    b_rx_done = 1'b0;
    guard = 0;
    while ((guard < 3 || b_busy) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("b_completes", 32'(b_busy), 32'd0);
    checkOutput("b_len", 32'(b_tx_seen - t0), 32'd9);
    checkOutput("b_frame_done", 32'(b_exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
